// File: rtl/seq_alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Bit 0 of the opcode marks the iterative ops (MUL/DIV), bit 1 marks SUB/DIV.
  function automatic logic is_iterative(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the pin wrapper (master) and seq_alu (slave).
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Senders
  // hold valid and payload stable until the transfer edge.
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 flag_z;
  logic                 flag_c;
  logic                 flag_v;
  logic                 flag_dz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_dz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, flag_dz
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative datapath: shift-add multiply (mode=0) or restoring divide (mode=1),
// one bit per step; res_next is the value the working register takes on the next step.
module seq_alu_muldiv #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   res_next
);

  logic                 mode_q;
  logic [WIDTH-1:0]     operand_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_geq;
  logic [WIDTH-1:0]     div_diff;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;

  // MUL: p = {acc, multiplier}; DIV: p = {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, operand_q} : '0);
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};

    div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_geq   = (div_shift >= {1'b0, operand_q});
    // True difference is below 2^WIDTH whenever div_geq holds, so mod-2^WIDTH is exact.
    div_diff  = div_shift[WIDTH-1:0] - operand_q;
    div_rem   = div_geq ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {div_rem, p_q[WIDTH-2:0], div_geq};

    res_next  = mode_q ? div_next : mul_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      operand_q <= '0;
      p_q       <= '0;
    end else if (load) begin
      mode_q    <= mode;
      operand_q <= mode ? b : a;
      p_q       <= mode ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
    end else if (step) begin
      p_q       <= res_next;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit unsigned ALU: single-cycle ADD/SUB, iterative MUL/DIV.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_alu_if.slave    bus,
  output alu_state_e  dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  alu_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic                 dz_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 fz_q, fc_q, fv_q, fdz_q;

  logic                 accept;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [WIDTH-1:0]     as_res;
  logic                 as_c;
  logic                 as_v;
  logic [2*WIDTH-1:0]   md_next;

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    if (bus.op == OP_SUB) begin
      as_res = diff_w[WIDTH-1:0];
      as_c   = diff_w[WIDTH];
      as_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
    end else begin
      as_res = sum_w[WIDTH-1:0];
      as_c   = sum_w[WIDTH];
      as_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && is_iterative(bus.op)),
    .step     (state == ST_BUSY),
    .mode     (bus.op == OP_DIV),
    .a        (bus.a),
    .b        (bus.b),
    .res_next (md_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      fz_q        <= 1'b0;
      fc_q        <= 1'b0;
      fv_q        <= 1'b0;
      fdz_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (is_iterative(bus.op)) begin
              state <= ST_BUSY;
              cnt   <= CNT_W'(WIDTH);
              dz_q  <= (bus.op == OP_DIV) && (bus.b == '0);
            end else begin
              state       <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= {{WIDTH{1'b0}}, as_res};
              fz_q        <= (as_res == '0);
              fc_q        <= as_c;
              fv_q        <= as_v;
              fdz_q       <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          // Last iteration: capture the datapath's post-step value directly.
          if (cnt == CNT_W'(1)) begin
            state       <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_next;
            fz_q        <= (md_next == '0);
            fc_q        <= 1'b0;
            fv_q        <= 1'b0;
            fdz_q       <= dz_q;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_z    = fz_q;
  assign bus.flag_c    = fc_q;
  assign bus.flag_v    = fv_q;
  assign bus.flag_dz   = fdz_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4 and WIDTH=8.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  seq_alu_if #(.WIDTH(4)) if4 ();
  seq_alu_if #(.WIDTH(8)) if8 ();
  alu_state_e dbg4;
  alu_state_e dbg8;

  seq_alu #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .dbg_state(dbg4));
  seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .dbg_state(dbg8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: issue one request, wait for the result, then consume it
  task automatic op4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     output logic [7:0] res, output logic [3:0] flg, output int lat);
    if4.op = op; if4.a = a; if4.b = b; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    lat = 0;
    while (!if4.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = if4.result;
    flg = {if4.flag_z, if4.flag_c, if4.flag_v, if4.flag_dz};
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
  endtask

  task automatic op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     output logic [15:0] res, output logic [3:0] flg, output int lat);
    if8.op = op; if8.a = a; if8.b = b; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = if8.result;
    flg = {if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_dz};
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [3:0]  flg;   // {z, c, v, dz}
    int          lat;
  } vec_t;

  vec_t v4 [10] = '{
    '{OP_ADD, 8'd9,  8'd8, 16'h01, 4'b0110, 0},
    '{OP_SUB, 8'd3,  8'd5, 16'h0E, 4'b0100, 0},
    '{OP_SUB, 8'd5,  8'd5, 16'h00, 4'b1000, 0},
    '{OP_ADD, 8'd7,  8'd1, 16'h08, 4'b0010, 0},
    '{OP_SUB, 8'd8,  8'd1, 16'h07, 4'b0010, 0},
    '{OP_MUL, 8'd15, 8'd15, 16'hE1, 4'b0000, 4},
    '{OP_MUL, 8'd0,  8'd9, 16'h00, 4'b1000, 4},
    '{OP_DIV, 8'd13, 8'd4, 16'h13, 4'b0000, 4},
    '{OP_DIV, 8'd7,  8'd0, 16'h7F, 4'b0001, 4},
    '{OP_DIV, 8'd0,  8'd0, 16'h0F, 4'b0001, 4}
  };

  vec_t v8 [4] = '{
    '{OP_MUL, 8'd255, 8'd255, 16'hFE01, 4'b0000, 8},
    '{OP_DIV, 8'd200, 8'd7,   16'h041C, 4'b0000, 8},
    '{OP_DIV, 8'd9,   8'd0,   16'h09FF, 4'b0001, 8},
    '{OP_ADD, 8'd200, 8'd100, 16'h002C, 4'b0100, 0}
  };

  initial begin
    logic [7:0]  r4;
    logic [15:0] r8;
    logic [3:0]  f;
    int          lat;
    int          w;

    n_tests = 0;
    n_fail  = 0;
    if4.in_valid = 0; if4.op = 0; if4.a = 0; if4.b = 0; if4.out_ready = 0;
    if8.in_valid = 0; if8.op = 0; if8.a = 0; if8.b = 0; if8.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg4), 32'(ST_IDLE));
    check("rst_in_ready", 32'(if4.in_ready), 32'd1);
    check("rst_out_valid", 32'(if4.out_valid), 32'd0);
    check("rst_result", 32'(if4.result), 32'd0);
    check("rst_flags", 32'({if4.flag_z, if4.flag_c, if4.flag_v, if4.flag_dz}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table, WIDTH=4
    foreach (v4[i]) begin
      exp_q.push_back(32'(v4[i].res));
      op4(v4[i].op, v4[i].a[3:0], v4[i].b[3:0], r4, f, lat);
      check($sformatf("w4_res_%0d", i), 32'(r4), exp_q.pop_front());
      check($sformatf("w4_flg_%0d", i), 32'(f), 32'(v4[i].flg));
      check($sformatf("w4_lat_%0d", i), 32'(lat), 32'(v4[i].lat));
      check($sformatf("w4_idle_%0d", i), 32'(if4.in_ready), 32'd1);
    end

    // backpressure on a finished MUL
    if4.op = OP_MUL; if4.a = 4'd15; if4.b = 4'd15; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    check("bp_busy_in_ready", 32'(if4.in_ready), 32'd0);
    w = 0;
    while (!if4.out_valid && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_latency", 32'(w), 32'd4);
    if4.op = OP_ADD; if4.a = 4'd1; if4.b = 4'd1; if4.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_res_%0d", k), 32'(if4.result), 32'hE1);
      check($sformatf("bp_hold_vld_%0d", k), 32'(if4.out_valid), 32'd1);
      check($sformatf("bp_hold_rdy_%0d", k), 32'(if4.in_ready), 32'd0);
      check($sformatf("bp_hold_flg_%0d", k),
            32'({if4.flag_z, if4.flag_c, if4.flag_v, if4.flag_dz}), 32'd0);
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    check("bp_release_state", 32'(dbg4), 32'(ST_IDLE));
    check("bp_release_rdy", 32'(if4.in_ready), 32'd1);
    check("bp_release_vld", 32'(if4.out_valid), 32'd0);

    // asynchronous reset two iterations into a DIV
    if4.op = OP_DIV; if4.a = 4'd13; if4.b = 4'd4; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("mid_busy_state", 32'(dbg4), 32'(ST_BUSY));
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(if4.out_valid), 32'd0);
    check("arst_result", 32'(if4.result), 32'd0);
    check("arst_in_ready", 32'(if4.in_ready), 32'd1);
    check("arst_state", 32'(dbg4), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op4(OP_ADD, 4'd2, 4'd3, r4, f, lat);
    check("post_rst_res", 32'(r4), 32'h05);
    check("post_rst_flg", 32'(f), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd0);

    // directed table, WIDTH=8
    foreach (v8[i]) begin
      exp_q.push_back(32'(v8[i].res));
      op8(v8[i].op, v8[i].a, v8[i].b, r8, f, lat);
      check($sformatf("w8_res_%0d", i), 32'(r8), exp_q.pop_front());
      check($sformatf("w8_flg_%0d", i), 32'(f), 32'(v8[i].flg));
      check($sformatf("w8_lat_%0d", i), 32'(lat), 32'(v8[i].lat));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Performs ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands.
- ADD/SUB are single-cycle; MUL (shift-add) and DIV (restoring) are iterative, one bit per cycle.
- Sits behind the tt_um top wrapper, which maps pins onto its operand, opcode and result ports.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  2  opcode: 00 ADD, 01 MUL, 10 SUB, 11 DIV.
- a  in  WIDTH  operand A (dividend / minuend).
- b  in  WIDTH  operand B (divisor / subtrahend).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  2*WIDTH  result word.
- flag_z  out  1  result == 0, over all 2*WIDTH bits.
- flag_c  out  1  ADD carry-out / SUB borrow; 0 for MUL/DIV.
- flag_v  out  1  signed (two's-complement) overflow for ADD/SUB; 0 for MUL/DIV.
- flag_dz  out  1  DIV with b == 0.

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, counter=0.
- Reset asserted in any state aborts the operation immediately; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); requests are not accepted in BUSY or DONE.
  - Accept = in_valid && in_ready at a rising edge; a, b and op are captured at that edge.
- IDLE, ADD/SUB accepted at edge k: result and flags registered at edge k; state -> DONE; out_valid high from edge k (1-cycle latency).
- IDLE, MUL/DIV accepted at edge k: operands loaded, counter=WIDTH, state -> BUSY.
- BUSY: one iteration per edge, counter decrements. At the edge where counter reaches 0, result and flags are registered and state -> DONE. out_valid rises after edge k+WIDTH.
- DONE: out_valid=1; result and flags are held stable.
  - out_ready=1 at an edge -> IDLE, out_valid=0, in_ready=1 on the next cycle.
  - Result register keeps its last value after DONE; it is don't-care while out_valid=0.
- ADD: result[WIDTH-1:0] = (a+b) mod 2^WIDTH; upper bits 0; flag_c = carry-out.
- SUB: result[WIDTH-1:0] = (a-b) mod 2^WIDTH; upper bits 0; flag_c = (a<b).
- flag_v (ADD/SUB only): set when the operand signs match/differ per standard rule and the result sign differs.
- MUL: result = a*b, full 2*WIDTH bits, no truncation.
- DIV: result = {remainder, quotient}, each WIDTH bits.
- DIV by zero: quotient = all ones, remainder = a, flag_dz=1. Latency is still WIDTH cycles (no early exit).
- flag_z is evaluated on the final 2*WIDTH-bit result for every op.
- in_valid while busy is ignored; the request must be held until in_ready.
- Illegal ops: none exist; all 4 encodings are defined.

Decomposition:
- Package seq_alu_pkg:
  - op localparams OP_ADD=2'b00, OP_MUL=2'b01, OP_SUB=2'b10, OP_DIV=2'b11.
  - FSM state encoding ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module seq_alu_muldiv:
  - Iterative shift-add / restoring-divide datapath with load, step and mode inputs.
  - Exposes the product or {rem, quo}.
- seq_alu holds the FSM, counter, add/sub logic and flag logic.

Test Plan:
- WIDTH=4, ADD a=9 b=8, out_ready=1 -> out_valid the cycle after accept; result=0x01, flag_c=1, flag_v=1, flag_z=0.
- SUB a=3 b=5 -> result=0x0E, flag_c=1, flag_v=0; SUB a=5 b=5 -> result=0x00, flag_z=1.
- MUL a=15 b=15 -> in_ready low for 4 cycles, then result=0xE1, all flags 0; MUL a=0 b=9 -> 0x00, flag_z=1.
- DIV a=13 b=4 -> result=0x13 (rem=1, quo=3) after 4 iterations; DIV a=7 b=0 -> result=0x7F, flag_dz=1.
- Backpressure: MUL done with out_ready=0 for 3 cycles -> result/flags stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-BUSY (DIV, 2 iterations in): rst_n low asynchronously -> out_valid=0, result=0, in_ready=1 immediately. A fresh ADD after release completes correctly.
- Rerun the MUL/DIV cases at WIDTH=8 (e.g. 255*255=0xFE01, 200/7 -> {4,28}) to confirm parametrisation.
